// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package periph_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    localparam int ARB_ADDR_W_DEF = 1;
    localparam int ARB_DATA_W_DEF = 16;

endpackage

// File: rtl/periph_bus_arbiter_pick.sv
// Combinational round-robin pick between two requesters; a tie goes to the one not served last.
module arb_rr_pick
    import periph_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_rr_last,
    output logic o_winner,
    output logic o_valid
);

    assign o_valid  = i_req0 | i_req1;
    assign o_winner = (i_req0 && i_req1) ? ((i_rr_last == M_CPU) ? M_DBG : M_CPU)
                                         : (i_req1 ? M_DBG : M_CPU);

endmodule

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one wait-capable peripheral slave between CPU (m0) and debug/DMA (m1).
// Define ARB_TIMEOUT_EN to add a BUSY watchdog that forces completion and pulses timeout_o.
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W_DEF,
    parameter int DATA_W = ARB_DATA_W_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_re_i,
    input  logic              m0_we_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_needWait_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_re_i,
    input  logic              m1_we_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_needWait_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic              s_re_o,
    output logic              s_we_o,
    inout  wire  [DATA_W-1:0] s_data_io,
    input  logic              s_needWait_i
`ifdef ARB_TIMEOUT_EN
    ,
    output logic              timeout_o
`endif
);

    arb_state_t        r_state, w_state_nxt;
    logic              r_grant, w_grant_nxt;
    logic              r_rr_last, w_rr_last_nxt;
    logic              w_req0, w_req1;
    logic              w_pick, w_pick_vld;
    logic              w_busy;
    logic              w_g_re, w_g_we, w_g_req;
    logic [ADDR_W-1:0] w_g_addr;
    logic [DATA_W-1:0] w_g_wdata;
    logic              w_done, w_tmo, w_release;

    assign w_req0 = m0_re_i | m0_we_i;
    assign w_req1 = m1_re_i | m1_we_i;

    arb_rr_pick u_pick (
        .i_req0    (w_req0),
        .i_req1    (w_req1),
        .i_rr_last (r_rr_last),
        .o_winner  (w_pick),
        .o_valid   (w_pick_vld)
    );

    // Reset masks the bus in the very cycle it is asserted, even mid-access.
    assign w_busy    = (r_state == ARB_BUSY) && !reset;
    assign w_g_re    = (r_grant == M_DBG) ? m1_re_i    : m0_re_i;
    assign w_g_we    = (r_grant == M_DBG) ? m1_we_i    : m0_we_i;
    assign w_g_addr  = (r_grant == M_DBG) ? m1_addr_i  : m0_addr_i;
    assign w_g_wdata = (r_grant == M_DBG) ? m1_wdata_i : m0_wdata_i;
    assign w_g_req   = w_g_re | w_g_we;
    assign w_done    = w_busy && w_g_req && !s_needWait_i;

`ifdef ARB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] r_tcnt;

    assign w_tmo     = w_busy && w_g_req && s_needWait_i && (r_tcnt == TCNT_W'(TIMEOUT_CYCLES));
    assign timeout_o = w_tmo;

    always_ff @(posedge clk) begin
        if (reset || w_state_nxt == ARB_IDLE) begin
            r_tcnt <= '0;
        end else if (r_state == ARB_BUSY && s_needWait_i) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    assign w_release = w_done | w_tmo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_grant   <= M_CPU;
            r_rr_last <= M_DBG;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_last <= w_rr_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_last_nxt = r_rr_last;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = w_pick;
                end
            end
            ARB_BUSY: begin
                // Dropping both strobes aborts without counting as a served turn.
                if (!w_g_req) begin
                    w_state_nxt = ARB_IDLE;
                end else if (w_release) begin
                    w_state_nxt   = ARB_IDLE;
                    w_rr_last_nxt = r_grant;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_addr_o      = '0;
        s_re_o        = 1'b0;
        s_we_o        = 1'b0;
        if (w_busy) begin
            s_addr_o = w_g_addr;
            s_we_o   = w_g_we;
            s_re_o   = w_g_re & ~w_g_we;
        end
        m0_needWait_o = w_req0 & ~(w_release && r_grant == M_CPU);
        m1_needWait_o = w_req1 & ~(w_release && r_grant == M_DBG);
    end

    assign s_data_io  = s_we_o ? w_g_wdata : {DATA_W{1'bz}};
    assign m0_rdata_o = (w_busy && r_grant == M_CPU && !w_tmo) ? s_data_io : '0;
    assign m1_rdata_o = (w_busy && r_grant == M_DBG && !w_tmo) ? s_data_io : '0;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed cycle table, alternation sequence, randomized traffic vs reference model.
module tb_periph_bus_arbiter;

    localparam int AW = 1;
    localparam int DW = 16;
`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 4;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] m0_addr_i, m1_addr_i;
    logic          m0_re_i, m0_we_i, m1_re_i, m1_we_i;
    logic [DW-1:0] m0_wdata_i, m1_wdata_i, m0_rdata_o, m1_rdata_o;
    logic          m0_needWait_o, m1_needWait_o;
    logic [AW-1:0] s_addr_o;
    logic          s_re_o, s_we_o, s_needWait_i;
    wire  [DW-1:0] s_data_io;
    logic [DW-1:0] slv_data;
`ifdef ARB_TIMEOUT_EN
    logic          timeout_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Slave model: drives the bus whenever the arbiter is not writing.
    assign s_data_io = s_we_o ? {DW{1'bz}} : slv_data;

    periph_bus_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .m0_addr_i     (m0_addr_i),
        .m0_re_i       (m0_re_i),
        .m0_we_i       (m0_we_i),
        .m0_wdata_i    (m0_wdata_i),
        .m0_rdata_o    (m0_rdata_o),
        .m0_needWait_o (m0_needWait_o),
        .m1_addr_i     (m1_addr_i),
        .m1_re_i       (m1_re_i),
        .m1_we_i       (m1_we_i),
        .m1_wdata_i    (m1_wdata_i),
        .m1_rdata_o    (m1_rdata_o),
        .m1_needWait_o (m1_needWait_o),
        .s_addr_o      (s_addr_o),
        .s_re_o        (s_re_o),
        .s_we_o        (s_we_o),
        .s_data_io     (s_data_io),
        .s_needWait_i  (s_needWait_i)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_o     (timeout_o)
`endif
    );

    typedef struct {
        logic          rst, re0, we0, re1, we1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] wd0, wd1;
        logic          sw;
        logic [DW-1:0] sd;
        logic          ere, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
        logic          ew0, ew1;
        logic [DW-1:0] erd0, erd1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t row(
        input logic rst, re0, we0, re1, we1,
        input logic [AW-1:0] a0, a1,
        input logic [DW-1:0] wd0, wd1,
        input logic sw,
        input logic [DW-1:0] sd,
        input logic ere, ewe,
        input logic [AW-1:0] eaddr,
        input logic [DW-1:0] edata,
        input logic ew0, ew1,
        input logic [DW-1:0] erd0, erd1);
        return '{rst, re0, we0, re1, we1, a0, a1, wd0, wd1, sw, sd,
                 ere, ewe, eaddr, edata, ew0, ew1, erd0, erd1};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset        = v.rst;
        m0_re_i      = v.re0;
        m0_we_i      = v.we0;
        m1_re_i      = v.re1;
        m1_we_i      = v.we1;
        m0_addr_i    = v.a0;
        m1_addr_i    = v.a1;
        m0_wdata_i   = v.wd0;
        m1_wdata_i   = v.wd1;
        s_needWait_i = v.sw;
        slv_data     = v.sd;
    endtask

    task automatic check_vec(input string t, input vec_t v);
        chk({t, ".s_re"},   s_re_o,        v.ere);
        chk({t, ".s_we"},   s_we_o,        v.ewe);
        chk({t, ".s_addr"}, s_addr_o,      v.eaddr);
        chk({t, ".s_data"}, s_data_io,     v.edata);
        chk({t, ".wait0"},  m0_needWait_o, v.ew0);
        chk({t, ".wait1"},  m1_needWait_o, v.ew1);
        chk({t, ".rdata0"}, m0_rdata_o,    v.erd0);
        chk({t, ".rdata1"}, m1_rdata_o,    v.erd1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: owner of the bus (-1 = none), last served master, wait cycles seen.
    logic          rre[2], rwe[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rwd[2];
    int            own;
    logic          last;
    int            wcnt;

    task automatic rnd_req(input int n);
        int k;
        k      = $urandom_range(0, 9);
        rre[n] = (k >= 4 && k <= 7) || (k == 9);
        rwe[n] = (k >= 8);
        ra[n]  = AW'($urandom);
        rwd[n] = DW'($urandom);
    endtask

    initial begin
        vec_t v, z;
        z = row(0,0,0,0,0, 0,0, 0,0, 0, 0, 0,0, 0, 0, 0,0, 0,0);

        // reset state
        tbl.push_back(row(1,0,0,0,0, 0,0, 0,0, 0,16'h0000, 0,0,0,16'h0000, 0,0,0,0));
        tbl.push_back(row(1,0,0,0,0, 0,0, 0,0, 0,16'h0000, 0,0,0,16'h0000, 0,0,0,0));
        // m0 writes 1234 to addr 1
        tbl.push_back(row(0,0,1,0,0, 1,0, 16'h1234,0, 0,16'h0000, 0,0,0,16'h0000, 1,0,0,0));
        tbl.push_back(row(0,0,1,0,0, 1,0, 16'h1234,0, 0,16'h0000, 0,1,1,16'h1234, 0,0,16'h1234,0));
        tbl.push_back(row(0,0,0,0,0, 0,0, 0,0, 0,16'h0000, 0,0,0,16'h0000, 0,0,0,0));
        // simultaneous reads from reset: m0 then m1
        tbl.push_back(row(1,0,0,0,0, 0,0, 0,0, 0,16'h0000, 0,0,0,16'h0000, 0,0,0,0));
        tbl.push_back(row(0,1,0,1,0, 0,1, 0,0, 0,16'hBEEF, 0,0,0,16'hBEEF, 1,1,0,0));
        tbl.push_back(row(0,1,0,1,0, 0,1, 0,0, 0,16'hBEEF, 1,0,0,16'hBEEF, 0,1,16'hBEEF,0));
        tbl.push_back(row(0,0,0,1,0, 0,1, 0,0, 0,16'hBEEF, 0,0,0,16'hBEEF, 0,1,0,0));
        tbl.push_back(row(0,0,0,1,0, 0,1, 0,0, 0,16'hBEEF, 1,0,1,16'hBEEF, 0,0,0,16'hBEEF));
        // slave waits 3 BUSY cycles; m1 stays stalled
        tbl.push_back(row(0,1,0,0,1, 0,1, 0,16'h5678, 0,16'hCAFE, 0,0,0,16'hCAFE, 1,1,0,0));
        tbl.push_back(row(0,1,0,0,1, 0,1, 0,16'h5678, 1,16'hCAFE, 1,0,0,16'hCAFE, 1,1,16'hCAFE,0));
        tbl.push_back(row(0,1,0,0,1, 0,1, 0,16'h5678, 1,16'hCAFE, 1,0,0,16'hCAFE, 1,1,16'hCAFE,0));
        tbl.push_back(row(0,1,0,0,1, 0,1, 0,16'h5678, 1,16'hCAFE, 1,0,0,16'hCAFE, 1,1,16'hCAFE,0));
        tbl.push_back(row(0,1,0,0,1, 0,1, 0,16'h5678, 0,16'hCAFE, 1,0,0,16'hCAFE, 0,1,16'hCAFE,0));
        tbl.push_back(row(0,0,0,0,1, 0,1, 0,16'h5678, 0,16'hCAFE, 0,0,0,16'hCAFE, 0,1,0,0));
        tbl.push_back(row(0,0,0,0,1, 0,1, 0,16'h5678, 0,16'hCAFE, 0,1,1,16'h5678, 0,0,0,16'h5678));
        // reset during a BUSY write, then m0 wins the tie
        tbl.push_back(row(0,0,1,0,0, 1,0, 16'h1234,0, 0,16'h0000, 0,0,0,16'h0000, 1,0,0,0));
        tbl.push_back(row(1,0,1,1,0, 1,0, 16'h1234,0, 0,16'h0000, 0,0,0,16'h0000, 1,1,0,0));
        tbl.push_back(row(0,0,1,1,0, 1,0, 16'h1234,0, 0,16'h0000, 0,0,0,16'h0000, 1,1,0,0));
        tbl.push_back(row(0,0,1,1,0, 1,0, 16'h1234,0, 0,16'h0000, 0,1,1,16'h1234, 0,1,16'h1234,0));
        // abort by m1 keeps rr_last, so m1 still wins the following tie
        tbl.push_back(row(0,0,0,1,0, 0,1, 0,0, 0,16'h0000, 0,0,0,16'h0000, 0,1,0,0));
        tbl.push_back(row(0,0,0,0,0, 0,1, 0,0, 0,16'h0000, 0,0,1,16'h0000, 0,0,0,0));
        tbl.push_back(row(0,1,0,1,0, 0,1, 0,0, 0,16'h0F0F, 0,0,0,16'h0F0F, 1,1,0,0));
        tbl.push_back(row(0,1,0,1,0, 0,1, 0,0, 0,16'h0F0F, 1,0,1,16'h0F0F, 1,0,0,16'h0F0F));
        tbl.push_back(row(0,0,0,0,0, 0,0, 0,0, 0,16'h0000, 0,0,0,16'h0000, 0,0,0,0));

        v = z;
        v.rst = 1'b1;
        drive(v);
        next_cycle();

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_vec($sformatf("row%0d", i), tbl[i]);
            next_cycle();
        end

        // Both masters request continuously: grants alternate m0,m1,...
        v = z;
        v.rst = 1'b1;
        drive(v);
        next_cycle();
        v = z;
        v.re0 = 1'b1;
        v.re1 = 1'b1;
        v.a1  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(v);
            @(negedge clk);
            if (k % 2 == 1) begin
                chk($sformatf("alt%0d.s_re", k), s_re_o, 1);
                chk($sformatf("alt%0d.grant", k), s_addr_o, (k / 2) % 2);
            end else begin
                chk($sformatf("alt%0d.idle", k), s_re_o, 0);
            end
            next_cycle();
        end

`ifdef ARB_TIMEOUT_EN
        // Slave stuck waiting: forced completion after TMO wait cycles, then m1 is served.
        v = z;
        v.rst = 1'b1;
        drive(v);
        next_cycle();
        v = z;
        v.re0 = 1'b1;
        v.re1 = 1'b1;
        v.a1  = 1'b1;
        v.sw  = 1'b1;
        v.sd  = 16'h1111;
        for (int k = 0; k <= TMO + 1; k++) begin
            drive(v);
            @(negedge clk);
            if (k <= TMO) begin
                chk($sformatf("tmo%0d.pulse", k), timeout_o, 0);
                chk($sformatf("tmo%0d.wait0", k), m0_needWait_o, 1);
            end else begin
                chk("tmo.pulse", timeout_o, 1);
                chk("tmo.wait0", m0_needWait_o, 0);
                chk("tmo.rdata0", m0_rdata_o, 0);
                chk("tmo.wait1", m1_needWait_o, 1);
            end
            next_cycle();
        end
        v.re0 = 1'b0;
        v.sw  = 1'b0;
        drive(v);
        @(negedge clk);
        chk("tmo.after_idle", timeout_o, 0);
        next_cycle();
        drive(v);
        @(negedge clk);
        chk("tmo.next_grant", s_addr_o, 1);
        chk("tmo.next_wait1", m1_needWait_o, 0);
        chk("tmo.next_pulse", timeout_o, 0);
        next_cycle();
`endif

        // Randomized traffic against the reference model.
        own  = -1;
        last = 1'b1;
        wcnt = 0;
        rnd_req(0);
        rnd_req(1);
        for (int c = 0; c < 400; c++) begin
            logic req[2];
            logic done, tmo;
            int   g;
            v.rst = (c == 0) || ($urandom_range(0, 49) == 0);
            v.re0 = rre[0];  v.we0 = rwe[0];  v.a0 = ra[0];  v.wd0 = rwd[0];
            v.re1 = rre[1];  v.we1 = rwe[1];  v.a1 = ra[1];  v.wd1 = rwd[1];
            v.sw  = ($urandom_range(0, 9) < 3);
            v.sd  = DW'($urandom);
            req[0] = rre[0] | rwe[0];
            req[1] = rre[1] | rwe[1];
            v.ere = 1'b0;  v.ewe = 1'b0;  v.eaddr = '0;  v.edata = v.sd;
            v.ew0 = req[0];  v.ew1 = req[1];  v.erd0 = '0;  v.erd1 = '0;
            done = 1'b0;
            tmo  = 1'b0;
            g    = own;
            if (!v.rst && own >= 0) begin
                v.ewe   = rwe[g];
                v.ere   = rre[g] & ~rwe[g];
                v.eaddr = ra[g];
                if (v.ewe) v.edata = rwd[g];
                done = req[g] && !v.sw;
`ifdef ARB_TIMEOUT_EN
                tmo  = req[g] && v.sw && (wcnt == TMO);
`endif
                if (g == 0) begin
                    v.erd0 = tmo ? '0 : v.edata;
                    if (done || tmo) v.ew0 = 1'b0;
                end else begin
                    v.erd1 = tmo ? '0 : v.edata;
                    if (done || tmo) v.ew1 = 1'b0;
                end
            end
            drive(v);
            @(negedge clk);
            check_vec("rnd", v);
`ifdef ARB_TIMEOUT_EN
            chk("rnd.timeout", timeout_o, tmo);
`endif
            if (v.rst) begin
                own  = -1;
                last = 1'b1;
                wcnt = 0;
            end else if (own < 0) begin
                if (req[0] && req[1]) own = last ? 0 : 1;
                else if (req[0])      own = 0;
                else if (req[1])      own = 1;
                wcnt = 0;
            end else if (!req[g] || done || tmo) begin
                if (req[g]) last = (g == 1);
                own  = -1;
                wcnt = 0;
            end else if (v.sw) begin
                wcnt++;
            end
            for (int n = 0; n < 2; n++) begin
                logic w;
                w = (n == 0) ? v.ew0 : v.ew1;
                if (!req[n] || !w) rnd_req(n);
                else if ($urandom_range(0, 24) == 0) begin
                    rre[n] = 1'b0;
                    rwe[n] = 1'b0;
                end
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
